// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//  Bundles the two requester handshakes (port A: pipeline MEM stage, port B:
//  debug/program loader) and the strobe-driven data-memory bus that the
//  arbiter owns.
//  Modports:
//   slave  - the arbiter's view: takes requests and Read_Data, drives acks,
//            rdata, stalls, err and the memory address/data/strobes.
//   master - the requesters' and memory's view: the opposite directions.
//  Signals (all 16-bit buses unmodified):
//   a_req/a_we/a_addr/a_wdata -> request side of port A
//   a_ack/a_rdata/a_stall     <- completion, load data, pipeline freeze
//   b_*                          same set for port B
//   mem_addr/mem_wdata/mem_mw/mem_mr <- memory Address, Write_Data, MW, MR
//   mem_rdata                         -> memory Read_Data
//   err                               <- out-of-range pulse, valid with ack
interface dmem_arbiter_if;
  logic        a_req;
  logic        a_we;
  logic [15:0] a_addr;
  logic [15:0] a_wdata;
  logic        a_ack;
  logic [15:0] a_rdata;
  logic        a_stall;

  logic        b_req;
  logic        b_we;
  logic [15:0] b_addr;
  logic [15:0] b_wdata;
  logic        b_ack;
  logic [15:0] b_rdata;
  logic        b_stall;

  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_mw;
  logic        mem_mr;
  logic [15:0] mem_rdata;
  logic        err;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_ack, a_rdata, a_stall,
    input  b_req, b_we, b_addr, b_wdata,
    output b_ack, b_rdata, b_stall,
    output mem_addr, mem_wdata, mem_mw, mem_mr,
    input  mem_rdata,
    output err
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_ack, a_rdata, a_stall,
    output b_req, b_we, b_addr, b_wdata,
    input  b_ack, b_rdata, b_stall,
    input  mem_addr, mem_wdata, mem_mw, mem_mr,
    output mem_rdata,
    input  err
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//  Shares the strobe-driven 16-bit data memory between port A (pipeline load/
//  store) and port B (debug/program loader). Each access walks
//  IDLE -> SETUP -> STROBE -> CAPTURE, giving one clean MW or MR strobe per
//  access, an ack three cycles after the request is first seen in IDLE, and
//  one access every four cycles. Port A has priority; after STARVE_LIMIT
//  consecutive A grants with B waiting, B is forced through.
//  Parameters:
//   ADDR_DEPTH   - implemented words, valid addresses 0..ADDR_DEPTH-1
//   STARVE_LIMIT - A grants tolerated while B waits (1..15)
//  Ports:
//   clk  - clock, all state on the rising edge
//   rst  - synchronous active-high reset
//   bus  - dmem_arbiter_if.slave: both requester handshakes + memory bus
//  Configuration:
//   DMEM_BOUNDS_CHECK_EN - when defined, an address >= ADDR_DEPTH suppresses
//   the strobe and the access completes with rdata = 0 and err = 1.
//   Undefined: every access strobes the memory and err stays 0.
module dmem_arbiter #(
  parameter int ADDR_DEPTH   = 16,
  parameter int STARVE_LIMIT = 4
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

`ifdef DMEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  localparam logic [31:0] DEPTH_W = 32'(ADDR_DEPTH);
  localparam logic [3:0]  LIMIT_W = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    STROBE  = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        grant_a;
  logic        grant_b;
  logic        starved;

  logic        owner_b;
  logic        lat_we;
  logic        lat_oob;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [3:0]  starve_cnt;
  logic [15:0] a_rdata_q;
  logic [15:0] b_rdata_q;

  logic [15:0] sel_addr;
  logic [15:0] sel_wdata;
  logic        sel_we;
  logic        sel_oob;
  logic [15:0] cap_data;

  assign starved = (starve_cnt == LIMIT_W);

  // Next state and arbitration. B only wins over a simultaneous A request
  // once A has been granted STARVE_LIMIT times in a row while B waited.
  always_comb begin
    state_next = state;
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.b_req && (!bus.a_req || starved)) begin
          grant_b    = 1'b1;
          state_next = SETUP;
        end else if (bus.a_req) begin
          grant_a    = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP:   state_next = STROBE;
      STROBE:  state_next = CAPTURE;
      CAPTURE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request fields of whichever port is being granted this cycle.
  always_comb begin
    sel_addr  = bus.a_addr;
    sel_wdata = bus.a_wdata;
    sel_we    = bus.a_we;
    if (grant_b) begin
      sel_addr  = bus.b_addr;
      sel_wdata = bus.b_wdata;
      sel_we    = bus.b_we;
    end
    sel_oob = BOUNDS_EN && ({16'h0000, sel_addr} >= DEPTH_W);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The address/data registers are the memory bus itself, so they present
  // the latched request from SETUP onwards and keep their value in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_b <= 1'b0;
      lat_we  <= 1'b0;
      lat_oob <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
    end else if (grant_a || grant_b) begin
      owner_b <= grant_b;
      lat_we  <= sel_we;
      lat_oob <= sel_oob;
      addr_q  <= sel_addr;
      wdata_q <= sel_wdata;
    end
  end

  // Counts A grants made while B is waiting; any B grant or B dropping its
  // request starts the count over.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (grant_b) begin
      starve_cnt <= 4'd0;
    end else if (grant_a && bus.b_req) begin
      starve_cnt <= starve_cnt + 4'd1;
    end else if (!bus.b_req) begin
      starve_cnt <= 4'd0;
    end
  end

  // Read_Data is valid while MR is high, so it is registered on the edge
  // that leaves STROBE; the owner's rdata is then stable for the whole
  // CAPTURE cycle alongside its ack. Stores leave rdata untouched unless the
  // access was out of range, which always returns zero.
  assign cap_data = lat_oob ? 16'h0000 : bus.mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_rdata_q <= 16'h0000;
      b_rdata_q <= 16'h0000;
    end else if (state == STROBE && (!lat_we || lat_oob)) begin
      if (owner_b) begin
        b_rdata_q <= cap_data;
      end else begin
        a_rdata_q <= cap_data;
      end
    end
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_mw    = (state == STROBE) && lat_we && !lat_oob;
  assign bus.mem_mr    = (state == STROBE) && !lat_we && !lat_oob;

  assign bus.a_ack   = (state == CAPTURE) && !owner_b;
  assign bus.b_ack   = (state == CAPTURE) && owner_b;
  assign bus.err     = (state == CAPTURE) && lat_oob;
  assign bus.a_rdata = a_rdata_q;
  assign bus.b_rdata = b_rdata_q;
  assign bus.a_stall = bus.a_req && !bus.a_ack;
  assign bus.b_stall = bus.b_req && !bus.b_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//  Self-checking bench for dmem_arbiter. A transaction-level reference model
//  (decision points every four cycles, ack three cycles after grant, an
//  abstract memory array and a starvation tally) predicts every output each
//  cycle; directed sequences cover the store/load, starvation, back-to-back,
//  reset-during-strobe, out-of-range and late-input-change cases, followed by
//  randomized traffic on both ports.
//  Honors DMEM_BOUNDS_CHECK_EN the same way the design does.
module tb_dmem_arbiter;
  localparam int ADDR_DEPTH   = 16;
  localparam int STARVE_LIMIT = 4;

`ifdef DMEM_BOUNDS_CHECK_EN
  localparam bit BCHK = 1'b1;
`else
  localparam bit BCHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  dmem_arbiter_if bus();

  dmem_arbiter #(
    .ADDR_DEPTH  (ADDR_DEPTH),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Deterministic power-up memory contents shared by memory and model.
  function automatic logic [15:0] initVal(input logic [15:0] a);
    return 16'(a * 16'h1357) ^ 16'hA5A5;
  endfunction

  // Memory attached to the arbiter: asynchronous read, write on MW.
  logic [15:0] tb_mem  [0:65535];
  bit          tb_wr   [0:65535];
  assign bus.mem_rdata = tb_wr[bus.mem_addr] ? tb_mem[bus.mem_addr] : initVal(bus.mem_addr);

  always @(posedge clk) begin
    if (bus.mem_mw) begin
      tb_mem[bus.mem_addr] <= bus.mem_wdata;
      tb_wr[bus.mem_addr]  <= 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] ref_mem [0:65535];
  bit          ref_wr  [0:65535];
  bit          mon_en  = 1'b0;
  bit          m_busy  = 1'b0;
  bit          m_own_b = 1'b0;
  bit          m_we    = 1'b0;
  bit          m_oob   = 1'b0;
  logic [15:0] m_addr  = 16'h0;
  logic [15:0] m_wdata = 16'h0;
  logic [15:0] m_ard   = 16'h0;
  logic [15:0] m_brd   = 16'h0;
  int          m_gcyc  = 0;
  int          m_starve = 0;
  int          cyc     = 0;
  int          mw_count = 0;
  int          mr_count = 0;
  int          k;
  bit          idle_now;
  bit          e_aack, e_back, e_mw, e_mr, e_err;
  logic [15:0] rv;

  // Every cycle: predict outputs from the transaction in flight, compare,
  // then take the arbitration decision if the arbiter is free.
  always @(negedge clk) begin
    if (mon_en) begin
      idle_now = !m_busy;
      e_aack = 1'b0; e_back = 1'b0; e_mw = 1'b0; e_mr = 1'b0; e_err = 1'b0;
      if (m_busy) begin
        k = cyc - m_gcyc;
        if (k == 2) begin
          e_mw = m_we && !m_oob;
          e_mr = !m_we && !m_oob;
          checkOutput("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
          if (m_we) checkOutput("mem_wdata", 32'(bus.mem_wdata), 32'(m_wdata));
        end
        if (k == 3) begin
          e_aack = !m_own_b;
          e_back = m_own_b;
          e_err  = m_oob;
          rv = ref_wr[m_addr] ? ref_mem[m_addr] : initVal(m_addr);
          if (m_oob) begin
            if (m_own_b) m_brd = 16'h0; else m_ard = 16'h0;
          end else if (!m_we) begin
            if (m_own_b) m_brd = rv; else m_ard = rv;
          end else begin
            ref_mem[m_addr] = m_wdata;
            ref_wr[m_addr]  = 1'b1;
          end
          m_busy = 1'b0;
        end
      end
      checkOutput("a_ack",   32'(bus.a_ack),   32'(e_aack));
      checkOutput("b_ack",   32'(bus.b_ack),   32'(e_back));
      checkOutput("mem_mw",  32'(bus.mem_mw),  32'(e_mw));
      checkOutput("mem_mr",  32'(bus.mem_mr),  32'(e_mr));
      checkOutput("err",     32'(bus.err),     32'(e_err));
      checkOutput("a_stall", 32'(bus.a_stall), 32'(bus.a_req && !e_aack));
      checkOutput("b_stall", 32'(bus.b_stall), 32'(bus.b_req && !e_back));
      checkOutput("a_rdata", 32'(bus.a_rdata), 32'(m_ard));
      checkOutput("b_rdata", 32'(bus.b_rdata), 32'(m_brd));
      if (bus.mem_mw) mw_count++;
      if (bus.mem_mr) mr_count++;

      if (rst) begin
        m_busy = 1'b0; m_starve = 0; m_ard = 16'h0; m_brd = 16'h0;
      end else if (idle_now) begin
        if (bus.b_req && (!bus.a_req || m_starve == STARVE_LIMIT)) begin
          m_busy = 1'b1; m_own_b = 1'b1; m_gcyc = cyc;
          m_we = bus.b_we; m_addr = bus.b_addr; m_wdata = bus.b_wdata;
          m_starve = 0;
        end else if (bus.a_req) begin
          m_busy = 1'b1; m_own_b = 1'b0; m_gcyc = cyc;
          m_we = bus.a_we; m_addr = bus.a_addr; m_wdata = bus.a_wdata;
          m_starve = bus.b_req ? m_starve + 1 : 0;
        end else begin
          m_starve = 0;
        end
        m_oob = m_busy && BCHK && (int'(m_addr) >= ADDR_DEPTH);
      end else if (!bus.b_req) begin
        m_starve = 0;
      end
      cyc++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic goQuiet();
    stepCycle();
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    for (int i = 0; i < 10 && m_busy; i++) stepCycle();
    stepCycle();
  endtask

  task automatic waitAck(input bit port_b, output int lat, output logic [15:0] rd, output logic er);
    bit got = 1'b0;
    lat = 0; rd = 16'h0; er = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      #1;
      if (port_b ? bus.b_ack : bus.a_ack) begin
        got = 1'b1;
        rd  = port_b ? bus.b_rdata : bus.a_rdata;
        er  = bus.err;
      end else begin
        lat++;
      end
    end
    if (!got) checkOutput("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic doAccess(input bit port_b, input bit we, input logic [15:0] addr,
                          input logic [15:0] wdata, output int lat,
                          output logic [15:0] rd, output logic er);
    stepCycle();
    if (port_b) begin
      bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata;
    end else begin
      bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata;
    end
    waitAck(port_b, lat, rd, er);
  endtask

  // Random traffic: a granted requester keeps req high until its ack; every
  // other field (and an ungranted req) may change any cycle.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      stepCycle();
      if (!(bus.a_req && m_busy && !m_own_b)) bus.a_req = ($urandom % 100) < 60;
      if (!(bus.b_req && m_busy && m_own_b))  bus.b_req = ($urandom % 100) < 45;
      bus.a_we    = 1'($urandom);
      bus.b_we    = 1'($urandom);
      bus.a_addr  = 16'($urandom_range(0, 19));
      bus.b_addr  = 16'($urandom_range(0, 19));
      bus.a_wdata = 16'($urandom);
      bus.b_wdata = 16'($urandom);
    end
  endtask

  // ---------------- main sequence ----------------
  int          lat, lat2, cnt_a, mw0, mr0;
  logic [15:0] rd;
  logic        er;
  bit          got_b;

  initial begin
    rst = 1'b1;
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = 16'h0; bus.a_wdata = 16'h0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = 16'h0; bus.b_wdata = 16'h0;
    stepCycle();
    mon_en = 1'b1;
    stepCycle();
    checkOutput("rst_mem_addr",  32'(bus.mem_addr),  32'h0);
    checkOutput("rst_mem_wdata", 32'(bus.mem_wdata), 32'h0);
    checkOutput("rst_a_rdata",   32'(bus.a_rdata),   32'h0);
    checkOutput("rst_b_rdata",   32'(bus.b_rdata),   32'h0);
    rst = 1'b0;
    goQuiet();

    // store then load at address 5
    mw0 = mw_count;
    doAccess(1'b0, 1'b1, 16'd5, 16'h0003, lat, rd, er);
    checkOutput("t1_store_lat", 32'(lat), 32'd3);
    checkOutput("t1_mw_pulses", 32'(mw_count - mw0), 32'd1);
    goQuiet();
    doAccess(1'b0, 1'b0, 16'd5, 16'h0, lat, rd, er);
    checkOutput("t1_load_lat", 32'(lat), 32'd3);
    checkOutput("t1_load_data", 32'(rd), 32'h0003);
    goQuiet();

    // both request continuously: A four times, then B
    stepCycle();
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 16'd1;
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 16'd2;
    cnt_a = 0; got_b = 1'b0;
    for (int i = 0; i < 40 && !got_b; i++) begin
      @(negedge clk);
      #1;
      if (bus.a_ack) cnt_a++;
      if (bus.b_ack) got_b = 1'b1;
    end
    checkOutput("t2_b_granted", 32'(got_b), 32'd1);
    checkOutput("t2_a_before_b", 32'(cnt_a), 32'(STARVE_LIMIT));
    goQuiet();

    // back-to-back loads with req held across the ack
    mr0 = mr_count;
    doAccess(1'b0, 1'b0, 16'd2, 16'h0, lat, rd, er);
    stepCycle();
    bus.a_addr = 16'd3;
    waitAck(1'b0, lat2, rd, er);
    checkOutput("t3_ack_spacing", 32'(lat2 + 1), 32'd4);
    checkOutput("t3_mr_pulses", 32'(mr_count - mr0), 32'd2);
    goQuiet();

    // reset while the strobe is up
    stepCycle();
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 16'd4;
    stepCycle();
    stepCycle();
    rst = 1'b1;
    bus.a_req = 1'b0;
    stepCycle();
    rst = 1'b0;
    checkOutput("t4_mr_after_rst", 32'(bus.mem_mr), 32'd0);
    checkOutput("t4_ack_after_rst", 32'(bus.a_ack), 32'd0);
    goQuiet();
    doAccess(1'b0, 1'b0, 16'd4, 16'h0, lat, rd, er);
    checkOutput("t4_fresh_lat", 32'(lat), 32'd3);
    goQuiet();

    // B store beyond the implemented depth
    mw0 = mw_count;
    doAccess(1'b1, 1'b1, 16'h0010, 16'hBEEF, lat, rd, er);
    checkOutput("t5_err", 32'(er), 32'(BCHK));
    checkOutput("t5_mw_pulses", 32'(mw_count - mw0), 32'(!BCHK));
`ifdef DMEM_BOUNDS_CHECK_EN
    checkOutput("t5_b_rdata", 32'(rd), 32'h0);
`endif
    goQuiet();

    // request fields change after grant; memory must see the latched ones
    stepCycle();
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 16'd7; bus.a_wdata = 16'h1234;
    stepCycle();
    checkOutput("t6_stall", 32'(bus.a_stall), 32'd1);
    bus.a_addr = 16'd9; bus.a_wdata = 16'hFFFF; bus.a_we = 1'b0;
    waitAck(1'b0, lat, rd, er);
    goQuiet();
    doAccess(1'b0, 1'b0, 16'd7, 16'h0, lat, rd, er);
    checkOutput("t6_latched_data", 32'(rd), 32'h1234);
    goQuiet();

    applyStimulus(1500);
    goQuiet();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    n_errors++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
